lap_period_decoder: RTL and testbench

LAP_PERIOD_DECODER -- requirements
Module: lap_period_decoder

---
 rtl/lap_period_decoder_if.sv | 14 +
 rtl/lap_period_decoder.sv | 77 +++++++
 tb/tb_lap_period_decoder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lap_period_decoder_if.sv
// lap_period_decoder_if: sample/lap inputs and decoded lap outputs of lap_period_decoder.
interface lap_period_decoder_if #(parameter int WL = 4);
  logic          iEN;
  logic          iLAP;
  logic [WL-1:0] iMV;
  logic          iCLR;
  logic [WL-1:0] oCNT;
  logic [WL-1:0] oLEN;
  logic          oVALID;
  logic          oLOCK;
  logic          oERR;
  modport master (output iEN, iLAP, iMV, iCLR, input oCNT, oLEN, oVALID, oLOCK, oERR);
  modport slave  (input iEN, iLAP, iMV, iCLR, output oCNT, oLEN, oVALID, oLOCK, oERR);
endinterface

// File: rtl/lap_period_decoder.sv
// lap_period_decoder: measures lap lengths in samples and locks onto an expected length.
// Define LAP_ERR_STICKY_EN to make oERR sticky until iCLR; otherwise it is a one-cycle pulse.
module lap_period_decoder #(
  parameter int WL       = 4,
  parameter int LOCK_CNT = 2
) (
  input logic iCLK,
  input logic iRSTn,
  lap_period_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;
  localparam logic [WL-1:0] MAX = '1;
  state_t        state_q, state_d;
  logic [WL-1:0] cnt_q, cnt_d, len_q, len_d, lap_len;
  logic [2:0]    mcnt_q, mcnt_d, mcnt_inc;
  logic          ovf_q, ovf_d, valid_q, valid_d, lock_q, lock_d, err_q, err_d;
  logic          sat, lap_end, match, fail;
  always_comb begin
    sat      = cnt_q == MAX;
    lap_end  = bus.iEN & bus.iLAP;
    lap_len  = sat ? MAX : cnt_q + WL'(1);
    match    = (lap_len == bus.iMV) && !ovf_q;
    mcnt_inc = mcnt_q + 3'd1;
    cnt_d    = lap_end ? '0 : (bus.iEN && !sat) ? cnt_q + WL'(1) : cnt_q;
    ovf_d    = lap_end ? 1'b0 : ovf_q | (bus.iEN & sat);
    valid_d  = lap_end && state_q != IDLE;
    len_d    = valid_d ? lap_len : len_q;
    fail     = lap_end && state_q == LOCKED && !match;
    state_d  = state_q;
    mcnt_d   = mcnt_q;
    if (lap_end) begin
      if (state_q == IDLE || !match) begin
        state_d = ACQ;
        mcnt_d  = '0;
      end else if (state_q == ACQ) begin
        mcnt_d  = mcnt_inc;
        state_d = (mcnt_inc == 3'(LOCK_CNT)) ? LOCKED : ACQ;
      end
    end
    lock_d = state_d == LOCKED;
`ifdef LAP_ERR_STICKY_EN
    err_d = fail | (err_q & ~bus.iCLR);
`else
    err_d = fail;
`endif
  end
`ifndef LAP_ERR_STICKY_EN
  logic unused_clr;
  assign unused_clr = bus.iCLR;
`endif
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mcnt_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mcnt_q  <= mcnt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end
  assign bus.oCNT   = cnt_q;
  assign bus.oLEN   = len_q;
  assign bus.oVALID = valid_q;
  assign bus.oLOCK  = lock_q;
  assign bus.oERR   = err_q;
endmodule

// File: tb/tb_lap_period_decoder.sv
// tb_lap_period_decoder: directed checks of lap_period_decoder (WL=4, LOCK_CNT=2, iMV=5).
module tb_lap_period_decoder;
`ifdef LAP_ERR_STICKY_EN
  localparam logic S = 1'b1;
`else
  localparam logic S = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  logic [6:0] obs;
  lap_period_decoder_if #(.WL(4)) b();
  lap_period_decoder #(.WL(4), .LOCK_CNT(2)) dut (.iCLK(clk), .iRSTn(rstn), .bus(b.slave));
  always #5 clk = ~clk;
  assign obs = {b.oVALID, b.oLOCK, b.oERR, b.oLEN};
  task automatic smp(input logic en, input logic lp);
    b.iEN = en;
    b.iLAP = lp;
    @(posedge clk);
    #1;
  endtask
  task automatic lap(input int len);
    for (int i = 0; i < len - 1; i++) smp(1'b1, 1'b0);
    smp(1'b1, 1'b1);
  endtask
  task automatic do_reset;
    rstn = 1'b0;
    b.iEN = 1'b0; b.iLAP = 1'b0; b.iCLR = 1'b0; b.iMV = 4'd5;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask
  task automatic chk(input string name, input logic [6:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: {valid,lock,err,len} got %b_%b_%b_%0d expected %b_%b_%b_%0d",
               name, obs[6], obs[5], obs[4], obs[3:0], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask
  task automatic test_reset;
    do_reset();
    chk("reset_outputs", 7'd0);
    n_run++;
    if (b.oCNT !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", b.oCNT); end
  endtask
  task automatic test_lock;
    do_reset();
    lap(3);   chk("first_lap_discarded", {3'b000, 4'd0});
    lap(5);   chk("acq_lap1", {3'b100, 4'd5});
    lap(5);   chk("acq_lap2_lock", {3'b110, 4'd5});
    smp(0, 0); chk("lock_hold", {3'b010, 4'd5});
  endtask
  task automatic test_mismatch;
    lap(6);   chk("locked_mismatch", {3'b101, 4'd6});
    smp(0, 0); chk("err_after_mismatch", {2'b00, S, 4'd6});
    lap(5);   chk("relock_lap1", {2'b10, S, 4'd5});
    lap(5);   chk("relock_lap2", {2'b11, S, 4'd5});
    b.iCLR = 1'b1; smp(0, 0); b.iCLR = 1'b0;
    chk("err_cleared", {3'b010, 4'd5});
  endtask
  task automatic test_en_gating;
    for (int i = 0; i < 4; i++) begin
      smp(1, 0);
      n_run++;
      if (b.oCNT !== 4'(i + 1)) begin n_fail++; $display("FAIL gate_cnt_en: got %0d expected %0d", b.oCNT, i + 1); end
      smp(0, 1);
      n_run++;
      if (b.oCNT !== 4'(i + 1)) begin n_fail++; $display("FAIL gate_cnt_hold: got %0d expected %0d", b.oCNT, i + 1); end
      chk("gate_no_valid", {3'b010, 4'd5});
    end
    smp(1, 1); chk("gate_lap", {3'b110, 4'd5});
    smp(0, 1);
    n_run++;
    if (b.oCNT !== 4'd0) begin n_fail++; $display("FAIL gate_cnt_after_lap: got %0d expected 0", b.oCNT); end
  endtask
  task automatic test_set_wins;
    b.iCLR = 1'b1; lap(6); b.iCLR = 1'b0;
    chk("err_set_with_clr", {3'b101, 4'd6});
    smp(0, 0); chk("err_after_set_with_clr", {2'b00, S, 4'd6});
  endtask
  task automatic test_saturation;
    do_reset();
    lap(1);
    lap(5); chk("sat_pre_lap", {3'b100, 4'd5});
    for (int i = 0; i < 20; i++) smp(1, 0);
    n_run++;
    if (b.oCNT !== 4'd15) begin n_fail++; $display("FAIL sat_cnt: got %0d expected 15", b.oCNT); end
    smp(1, 1); chk("sat_lap_len", {3'b100, 4'd15});
    lap(5); chk("sat_counter_cleared", {3'b100, 4'd5});
    lap(5); chk("sat_relock", {3'b110, 4'd5});
    b.iMV = 4'd15;
    lap(16); chk("max_len_no_ovf", {3'b110, 4'd15});
    lap(17); chk("max_len_ovf", {3'b101, 4'd15});
    b.iMV = 4'd5;
  endtask
  task automatic test_mv_zero;
    do_reset();
    b.iMV = 4'd0;
    lap(1);
    lap(1); chk("mv0_lap1", {3'b100, 4'd1});
    lap(1);
    lap(1); chk("mv0_no_lock", {3'b100, 4'd1});
    b.iMV = 4'd5;
  endtask
  task automatic test_mid_reset;
    do_reset();
    lap(1); lap(5); lap(5);
    chk("pre_reset_lock", {3'b110, 4'd5});
    smp(1, 0); smp(1, 0);
    #2 rstn = 1'b0;
    #1;
    chk("async_reset_outputs", 7'd0);
    n_run++;
    if (b.oCNT !== 4'd0) begin n_fail++; $display("FAIL async_reset_cnt: got %0d expected 0", b.oCNT); end
    @(posedge clk); #1 rstn = 1'b1;
    lap(5); chk("post_reset_discard", {3'b000, 4'd0});
    lap(5); chk("post_reset_lap", {3'b100, 4'd5});
  endtask
  initial begin
    b.iEN = 1'b0; b.iLAP = 1'b0; b.iCLR = 1'b0; b.iMV = 4'd5;
    test_reset();
    test_lock();
    test_mismatch();
    test_en_gating();
    test_set_wins();
    test_saturation();
    test_mv_zero();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
